iaoq_next_ctrl: RTL and testbench

Next-address controller that drives the load-enable and data inputs of the front and back instruction address offset queue registers. Each non-stalled cycle it advances the queue (front takes back; back takes back+4 or a branch target), which gives PA-RISC delayed-branch semantics. Branches that resolve during a stall are buffered and applied on the next advance. Delay-slot nullification (`,n` completer) is tracked with a registered flag.

---
 rtl/iaoq_pkg.sv | 16 +
 rtl/iaoq_next_ctrl.sv | 114 +++++++++++
 tb/tb_iaoq_next_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/iaoq_pkg.sv
// Shared definitions for the instruction address offset queue (IAOQ) next-address logic.
// Holds the queue widths, reset values and controller state encoding.
package iaoq_pkg;

    localparam int IAOQ_AW  = 8;
    localparam int IAOQ_INC = 4;

    localparam logic [IAOQ_AW-1:0] IAOQ_FRONT_RST = 8'h00;
    localparam logic [IAOQ_AW-1:0] IAOQ_BACK_RST  = 8'h04;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } iaoq_st_t;

endpackage

// File: rtl/iaoq_next_ctrl.sv
// Next-address controller for the front/back IAOQ registers: advances the queue each
// unstalled cycle, buffers branches resolved under stall, and tracks delay-slot nullification.
module iaoq_next_ctrl
    import iaoq_pkg::*;
#(
    parameter int              AW       = IAOQ_AW,
    parameter int              INC      = IAOQ_INC,
    parameter logic [AW-1:0]   BACK_RST = IAOQ_BACK_RST
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_valid,
    input  logic          br_taken,
    input  logic          br_null,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] back_q,
    output logic          front_le,
    output logic [AW-1:0] front_d,
    output logic          back_le,
    output logic [AW-1:0] back_d,
    output logic          slot_null,
    output logic          pend_ovf
);

    // The back register lives outside this block; its reset value must stay instruction aligned.
    if ((int'(BACK_RST) % INC) != 0) begin : g_bad_back_rst
        $error("iaoq_next_ctrl: BACK_RST not aligned to INC");
    end

    iaoq_st_t      state_q, state_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          pend_null_q, pend_null_d;
    logic          slot_null_q, slot_null_d;
    logic          pend_ovf_q, pend_ovf_d;
    logic          advance;
    logic [AW-1:0] back_inc;

    // Queue load enables and data: zero-cycle decision from state and inputs.
    always_comb begin
        advance  = !stall && !reset;
        back_inc = back_q + AW'(INC);
        front_le = advance;
        back_le  = advance;
        front_d  = back_q;
        if (state_q == PEND) begin
            back_d = pend_tgt_q;
        end else if (br_valid && br_taken) begin
            back_d = br_target;
        end else begin
            back_d = back_inc;
        end
    end

    // Redirect buffering, nullification and overflow next-state.
    always_comb begin
        state_d     = state_q;
        pend_tgt_d  = pend_tgt_q;
        pend_null_d = pend_null_q;
        slot_null_d = slot_null_q;
        pend_ovf_d  = pend_ovf_q;
        case (state_q)
            RUN: begin
                if (br_valid && stall) begin
                    state_d     = PEND;
                    pend_tgt_d  = br_taken ? br_target : back_inc;
                    pend_null_d = br_null;
                end else if (!stall) begin
                    slot_null_d = br_valid && br_null;
                end else begin
                    slot_null_d = slot_null_q;
                end
            end
            PEND: begin
                // Only one redirect can be held; later ones are dropped and flagged.
                if (br_valid) begin
                    pend_ovf_d = 1'b1;
                end else begin
                    pend_ovf_d = pend_ovf_q;
                end
                if (!stall) begin
                    state_d     = RUN;
                    slot_null_d = pend_null_q;
                end else begin
                    state_d     = PEND;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pend_tgt_q  <= {AW{1'b0}};
            pend_null_q <= 1'b0;
            slot_null_q <= 1'b0;
            pend_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_null_q <= pend_null_d;
            slot_null_q <= slot_null_d;
            pend_ovf_q  <= pend_ovf_d;
        end
    end

    assign slot_null = slot_null_q;
    assign pend_ovf  = pend_ovf_q;

endmodule

// File: tb/tb_iaoq_next_ctrl.sv
// Self-checking bench for iaoq_next_ctrl: directed scenarios then random traffic, checked
// against a redirect-queue reference model and the external front/back queue registers.
module tb_iaoq_next_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall, br_valid, br_taken, br_null;
    logic [7:0] br_target, back_q, front_q;
    logic       front_le, back_le, slot_null, pend_ovf;
    logic [7:0] front_d, back_d;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] tgt;
        logic       nul;
    } redir_t;

    redir_t     pq[$];
    logic       m_slot_null = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_front = 8'h00;
    logic [7:0] m_back = 8'h04;

    iaoq_next_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_null(br_null),
        .br_target(br_target), .back_q(back_q),
        .front_le(front_le), .front_d(front_d),
        .back_le(back_le), .back_d(back_d),
        .slot_null(slot_null), .pend_ovf(pend_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive, compare against the model, clock, then update model and queue regs.
    task automatic step(input logic s, input logic bv, input logic bt, input logic bn,
                        input logic [7:0] tg, input logic r);
        logic       exp_le;
        logic [7:0] exp_bd;
        logic [7:0] s_fd, s_bd;
        logic       s_fle, s_ble;
        reset = r; stall = s; br_valid = bv; br_taken = bt; br_null = bn; br_target = tg;
        #2;
        exp_le = !s && !r;
        if (pq.size() != 0)  exp_bd = pq[0].tgt;
        else if (bv && bt)   exp_bd = tg;
        else                 exp_bd = back_q + 8'd4;
        chk("front_le", {7'd0, front_le}, {7'd0, exp_le});
        chk("back_le", {7'd0, back_le}, {7'd0, exp_le});
        chk("front_d", front_d, back_q);
        chk("back_d", back_d, exp_bd);
        chk("slot_null", {7'd0, slot_null}, {7'd0, m_slot_null});
        chk("pend_ovf", {7'd0, pend_ovf}, {7'd0, m_ovf});
        chk("back_q_model", back_q, m_back);
        s_fd = front_d; s_bd = back_d; s_fle = front_le; s_ble = back_le;
        @(posedge clk);
        if (r) begin
            pq.delete();
            m_slot_null = 1'b0;
            m_ovf = 1'b0;
            m_front = 8'h00;
            m_back = 8'h04;
        end else begin
            if (pq.size() != 0) begin
                if (bv) m_ovf = 1'b1;
                if (!s) begin
                    m_slot_null = pq[0].nul;
                    void'(pq.pop_front());
                end
            end else if (bv && s) begin
                pq.push_back('{tgt: (bt ? tg : back_q + 8'd4), nul: bn});
            end else if (!s) begin
                m_slot_null = bv && bn;
            end
            if (!s) begin
                m_front = m_back;
                m_back = exp_bd;
            end
        end
        #1;
        if (r) begin
            front_q = 8'h00;
            back_q = 8'h04;
        end else begin
            if (s_fle) front_q = s_fd;
            if (s_ble) back_q = s_bd;
        end
        chk("front_q_model", front_q, m_front);
    endtask

    initial begin
        int guard;
        front_q = 8'h00; back_q = 8'h04;
        // Reset, then sequential run through the wrap point.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_slot_null", {7'd0, slot_null}, 8'h00);
        chk("rst_pend_ovf", {7'd0, pend_ovf}, 8'h00);
        chk("first_front", back_q, 8'h04);
        for (int i = 0; i < 66; i++) begin
            if (back_q == 8'hFC) begin
                reset = 1'b0; stall = 1'b0; br_valid = 1'b0; #1;
                chk("wrap_back_d", back_d, 8'h00);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        guard = 0;
        while (back_q != 8'h10 && guard < 100) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("reach_10", back_q, 8'h10);
        // Taken branch, no stall.
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
        chk("br_front", front_q, 8'h10);
        chk("br_back", back_q, 8'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("br_next", back_q, 8'h44);
        // Branch during a 3-cycle stall.
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_br_back", back_q, 8'h80);
        // Nullify, then nullify with a 2-cycle stall.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
        chk("null_set", {7'd0, slot_null}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("null_clr", {7'd0, slot_null}, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("null_hold", {7'd0, slot_null}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("null_clr2", {7'd0, slot_null}, 8'h00);
        // Overflow: second branch while pending.
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hC0, 1'b0);
        chk("ovf_set", {7'd0, pend_ovf}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_first_tgt", back_q, 8'h80);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_sticky", {7'd0, pend_ovf}, 8'h01);
        // Reset while a redirect is pending.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_back", back_q, 8'h08);
        chk("post_rst_ovf", {7'd0, pend_ovf}, 8'h00);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), {6'($urandom), 2'b00},
                 ($urandom_range(0, 49) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
